// File: rtl/boot_ctrl.sv
// boot_ctrl: streams a program into instruction memory, then runs the core
// out of reset until it parks on halt_pc or exceeds its cycle budget.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   load_valid/ready/data/last  program word stream (ready only while loading)
//   start                     begin a run, or re-run the loaded program
//   reload                    drop the program and return to loading
//   halt_pc, core_pc          halt (self-loop) address and live core PC
//   core_rst                  core reset, released only while running
//   imem_we/addr/wdata        instruction-memory write port
//   words_loaded              words written since loading began
//   cycle_count               cycles spent in the current or last run
//   done, pass                run finished; finished by halt, not timeout
module boot_ctrl #(
    parameter int XLEN        = 32,
    parameter int IMEM_DEPTH  = 256,
    parameter int CNT_W       = 16,
    parameter int CYCLE_LIMIT = 1000,
    parameter int HALT_HOLD   = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [XLEN-1:0]               load_data,
    input  logic                          load_last,
    input  logic                          start,
    input  logic                          reload,
    input  logic [XLEN-1:0]               halt_pc,
    input  logic [XLEN-1:0]               core_pc,
    output logic                          core_rst,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [XLEN-1:0]               imem_wdata,
    output logic [$clog2(IMEM_DEPTH):0]   words_loaded,
    output logic [CNT_W-1:0]              cycle_count,
    output logic                          done,
    output logic                          pass
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int HW = $clog2(HALT_HOLD + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_WAIT,
        S_RUN,
        S_HALT,
        S_TIMEOUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]    wptr;
    logic [AW:0]      wcnt;
    logic [CNT_W-1:0] cyc;
    logic [HW-1:0]    hold;
    logic             done_q;
    logic             pass_q;

    logic accept;
    logic last_beat;
    logic go;
    logic halt_det;
    logic tmo_det;
    logic enter_load;
    logic enter_run;

    assign accept     = load_valid & load_ready;
    // The final memory slot ends the load even without load_last.
    assign last_beat  = load_last | (wptr == AW'(IMEM_DEPTH - 1));
    assign go         = start & (wcnt != '0);
    assign halt_det   = (hold >= HW'(HALT_HOLD));
    assign tmo_det    = (cyc == CNT_W'(CYCLE_LIMIT - 1));
    assign enter_load = (state != S_LOAD) && (state_nxt == S_LOAD);
    assign enter_run  = (state != S_RUN) && (state_nxt == S_RUN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // reload is tested before start so it wins when both are high.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD: begin
                if (accept && last_beat) state_nxt = S_WAIT;
            end
            S_WAIT, S_HALT, S_TIMEOUT: begin
                if (reload)  state_nxt = S_LOAD;
                else if (go) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (halt_det)     state_nxt = S_HALT;
                else if (tmo_det) state_nxt = S_TIMEOUT;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        core_rst   = 1'b1;
        unique case (state)
            S_LOAD:  load_ready = 1'b1;
            S_RUN:   core_rst   = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr   <= '0;
            wcnt   <= '0;
            cyc    <= '0;
            hold   <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            if (accept) begin
                wptr <= wptr + AW'(1);
                wcnt <= wcnt + (AW+1)'(1);
            end else if (enter_load) begin
                wptr <= '0;
                wcnt <= '0;
            end

            if (enter_run) begin
                cyc  <= '0;
                hold <= '0;
            end else if (state == S_RUN) begin
                // Count only cycles that stay in RUN so the value
                // freezes at the last run cycle on exit.
                if (state_nxt == S_RUN) cyc <= cyc + CNT_W'(1);
                if (core_pc == halt_pc) begin
                    if (!halt_det) hold <= hold + HW'(1);
                end else begin
                    hold <= '0;
                end
            end

            done_q <= (state_nxt == S_HALT) || (state_nxt == S_TIMEOUT);
            pass_q <= (state_nxt == S_HALT);
        end
    end

    assign imem_we      = accept;
    assign imem_addr    = wptr;
    assign imem_wdata   = load_data;
    assign words_loaded = wcnt;
    assign cycle_count  = cyc;
    assign done         = done_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// tb_boot_ctrl: vector table, corner sequences and random load/run
// episodes checked against an outcome model of boot_ctrl.
module tb_boot_ctrl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CNT_W = 8;
    localparam int LIMIT = 10;
    localparam int HOLD  = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [XLEN-1:0]  load_data = '0;
    logic             load_last = 1'b0;
    logic             start = 1'b0;
    logic             reload = 1'b0;
    logic [XLEN-1:0]  halt_pc = '0;
    logic [XLEN-1:0]  core_pc = '0;
    logic             core_rst;
    logic             imem_we;
    logic [AW-1:0]    imem_addr;
    logic [XLEN-1:0]  imem_wdata;
    logic [AW:0]      words_loaded;
    logic [CNT_W-1:0] cycle_count;
    logic             done;
    logic             pass;

    int checks   = 0;
    int failures = 0;

    boot_ctrl #(
        .XLEN        (XLEN),
        .IMEM_DEPTH  (DEPTH),
        .CNT_W       (CNT_W),
        .CYCLE_LIMIT (LIMIT),
        .HALT_HOLD   (HOLD)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .start        (start),
        .reload       (reload),
        .halt_pc      (halt_pc),
        .core_pc      (core_pc),
        .core_rst     (core_rst),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .words_loaded (words_loaded),
        .cycle_count  (cycle_count),
        .done         (done),
        .pass         (pass)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        int v;
        int d;
        int last;
        int st;
        int rl;
        int pc;
        int rdy;
        int we;
        int addr;
        int wl;
        int crst;
        int dn;
        int ps;
        int cc;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic string nm(input int ep, input string s);
        return $sformatf("ep%0d.%s", ep, s);
    endfunction

    task automatic drive(input int v, input logic [31:0] d, input int last,
                         input int st, input int rl, input logic [31:0] pc);
        load_valid = (v != 0);
        load_data  = d;
        load_last  = (last != 0);
        start      = (st != 0);
        reload     = (rl != 0);
        core_pc    = pc;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        #2;
        chk("rst.rdy", 64'(load_ready), 64'd1);
        chk("rst.crst", 64'(core_rst), 64'd1);
        chk("rst.wl", 64'(words_loaded), 64'd0);
        chk("rst.cc", 64'(cycle_count), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.pass", 64'(pass), 64'd0);
        tick();
        RST = 1'b0;
    endtask

    task automatic load_one();
        drive(1, 32'hC0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic go_run();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted between edges must take effect before the next edge.
    task automatic pulse_rst(input string s);
        #2;
        RST = 1'b1;
        #1;
        chk({s, ".crst"}, 64'(core_rst), 64'd1);
        chk({s, ".done"}, 64'(done), 64'd0);
        chk({s, ".pass"}, 64'(pass), 64'd0);
        chk({s, ".rdy"}, 64'(load_ready), 64'd1);
        chk({s, ".wl"}, 64'(words_loaded), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
    endtask

    task automatic rand_load(input int ep);
        int last_idx;
        int exp_n;
        int acc;
        int guard;
        int v;
        logic [31:0] dat;
        last_idx = int'($urandom_range(0, DEPTH + 1));
        exp_n = (last_idx < DEPTH) ? last_idx + 1 : DEPTH;
        acc = 0;
        guard = 0;
        while (acc < exp_n && guard < 60) begin
            v = int'($urandom_range(0, 1));
            dat = $urandom;
            drive(v, dat, (acc == last_idx) ? 1 : 0,
                  int'($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3) == 0), dat);
            @(negedge CLK);
            chk(nm(ep, "ld.we"), 64'(imem_we), 64'(v));
            chk(nm(ep, "ld.rdy"), 64'(load_ready), 64'd1);
            chk(nm(ep, "ld.wl"), 64'(words_loaded), 64'(acc));
            if (v != 0) begin
                chk(nm(ep, "ld.addr"), 64'(imem_addr), 64'(acc));
                chk(nm(ep, "ld.wdata"), 64'(imem_wdata), 64'(dat));
                acc++;
            end
            tick();
            guard++;
        end
        if (acc < exp_n) begin
            checks++;
            failures++;
            $display("FAIL %s: got %0d beats expected %0d",
                     nm(ep, "ld.budget"), acc, exp_n);
        end
        drive(1, $urandom, 0, 0, 0, 0);
        @(negedge CLK);
        chk(nm(ep, "wt.we"), 64'(imem_we), 64'd0);
        chk(nm(ep, "wt.rdy"), 64'(load_ready), 64'd0);
        chk(nm(ep, "wt.wl"), 64'(words_loaded), 64'(exp_n));
        chk(nm(ep, "wt.crst"), 64'(core_rst), 64'd1);
        chk(nm(ep, "wt.done"), 64'(done), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // Outcome model: the run halts in the first cycle preceded by HOLD
    // consecutive halt_pc matches, otherwise times out at LIMIT-1.
    task automatic rand_run(input int ep);
        logic [31:0] hpc;
        logic [31:0] pcs[LIMIT];
        int bias;
        int streak;
        int end_i;
        bit found;
        hpc = $urandom;
        bias = int'($urandom_range(0, 4));
        for (int i = 0; i < LIMIT; i++) begin
            if (int'($urandom_range(0, 4)) < bias) pcs[i] = hpc;
            else pcs[i] = hpc ^ 32'($urandom_range(1, 255));
        end
        streak = 0;
        found = 1'b0;
        end_i = LIMIT - 1;
        for (int i = 0; i < LIMIT; i++) begin
            if (!found && streak >= HOLD) begin
                found = 1'b1;
                end_i = i;
            end
            streak = (pcs[i] == hpc) ? streak + 1 : 0;
        end
        halt_pc = hpc;
        go_run();
        for (int i = 0; i <= end_i; i++) begin
            drive(0, 0, 0, 0, 0, pcs[i]);
            @(negedge CLK);
            chk(nm(ep, $sformatf("run%0d.cc", i)), 64'(cycle_count), 64'(i));
            chk(nm(ep, $sformatf("run%0d.crst", i)), 64'(core_rst), 64'd0);
            chk(nm(ep, $sformatf("run%0d.done", i)), 64'(done), 64'd0);
            tick();
        end
        @(negedge CLK);
        chk(nm(ep, "end.done"), 64'(done), 64'd1);
        chk(nm(ep, "end.pass"), 64'(pass), 64'(found));
        chk(nm(ep, "end.cc"), 64'(cycle_count), 64'(end_i));
        chk(nm(ep, "end.crst"), 64'(core_rst), 64'd1);
        tick();
    endtask

    initial begin
        int nw;
        int choice;
        bit in_load;
        vec_t r;

        halt_pc = 32'd8;
        do_reset();

        //            v  d      lst st rl pc  rdy we addr wl crst dn ps cc
        tbl[0]  = '{1, 'hA0, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0};
        tbl[1]  = '{0, 0,    0, 1, 1, 0, 1, 0, 1,  1, 1, 0, 0, 0};
        tbl[2]  = '{1, 'hA1, 0, 0, 0, 0, 1, 1, 1,  1, 1, 0, 0, 0};
        tbl[3]  = '{1, 'hA2, 0, 0, 0, 0, 1, 1, 2,  2, 1, 0, 0, 0};
        tbl[4]  = '{1, 'hA3, 1, 0, 0, 0, 1, 1, 3,  3, 1, 0, 0, 0};
        tbl[5]  = '{1, 'hA4, 0, 0, 0, 0, 0, 0, -1, 4, 1, 0, 0, 0};
        tbl[6]  = '{0, 0,    0, 1, 0, 0, 0, 0, -1, 4, 1, 0, 0, 0};
        tbl[7]  = '{0, 0,    0, 0, 0, 0, 0, 0, -1, 4, 0, 0, 0, 0};
        tbl[8]  = '{0, 0,    0, 0, 0, 4, 0, 0, -1, 4, 0, 0, 0, 1};
        tbl[9]  = '{0, 0,    0, 0, 0, 8, 0, 0, -1, 4, 0, 0, 0, 2};
        tbl[10] = '{0, 0,    0, 0, 0, 8, 0, 0, -1, 4, 0, 0, 0, 3};
        tbl[11] = '{0, 0,    0, 0, 0, 8, 0, 0, -1, 4, 0, 0, 0, 4};
        tbl[12] = '{0, 0,    0, 0, 0, 8, 0, 0, -1, 4, 1, 1, 1, 4};
        tbl[13] = '{0, 0,    0, 0, 0, 0, 0, 0, -1, 4, 1, 1, 1, 4};

        for (int i = 0; i < 14; i++) begin
            r = tbl[i];
            drive(r.v, r.d, r.last, r.st, r.rl, r.pc);
            @(negedge CLK);
            chk(nm(i, "v.rdy"), 64'(load_ready), 64'(r.rdy));
            chk(nm(i, "v.we"), 64'(imem_we), 64'(r.we));
            if (r.addr >= 0)
                chk(nm(i, "v.addr"), 64'(imem_addr), 64'(r.addr));
            if (r.we != 0)
                chk(nm(i, "v.wdata"), 64'(imem_wdata), 64'(r.d));
            chk(nm(i, "v.wl"), 64'(words_loaded), 64'(r.wl));
            chk(nm(i, "v.crst"), 64'(core_rst), 64'(r.crst));
            chk(nm(i, "v.done"), 64'(done), 64'(r.dn));
            chk(nm(i, "v.pass"), 64'(pass), 64'(r.ps));
            chk(nm(i, "v.cc"), 64'(cycle_count), 64'(r.cc));
            tick();
        end

        // Overflow: six beats without last into a four-word memory.
        do_reset();
        drive(0, 0, 0, 1, 0, 0);
        tick();
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'hB0 + 32'(i), 0, 0, 0, 0);
            @(negedge CLK);
            nw += int'(imem_we);
            if (i < DEPTH) begin
                chk($sformatf("ovf%0d.we", i), 64'(imem_we), 64'd1);
                chk($sformatf("ovf%0d.addr", i), 64'(imem_addr), 64'(i));
            end else begin
                chk($sformatf("ovf%0d.we", i), 64'(imem_we), 64'd0);
                chk($sformatf("ovf%0d.rdy", i), 64'(load_ready), 64'd0);
            end
            tick();
        end
        chk("ovf.writes", 64'(nw), 64'(DEPTH));
        chk("ovf.wl", 64'(words_loaded), 64'(DEPTH));

        // Timeout: core never reaches halt_pc.
        do_reset();
        halt_pc = 32'd8;
        load_one();
        go_run();
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge CLK);
            chk($sformatf("tmo%0d.cc", i), 64'(cycle_count), 64'(i));
            chk($sformatf("tmo%0d.crst", i), 64'(core_rst), 64'd0);
            tick();
        end
        @(negedge CLK);
        chk("tmo.done", 64'(done), 64'd1);
        chk("tmo.pass", 64'(pass), 64'd0);
        chk("tmo.cc", 64'(cycle_count), 64'(LIMIT - 1));
        chk("tmo.crst", 64'(core_rst), 64'd1);
        tick();

        // Re-run from TIMEOUT; halt completes exactly at LIMIT-1.
        go_run();
        for (int i = 0; i < LIMIT; i++) begin
            drive(0, 0, 0, 0, 0, (i == LIMIT - 3 || i == LIMIT - 2) ? 8 : 0);
            @(negedge CLK);
            chk($sformatf("pri%0d.cc", i), 64'(cycle_count), 64'(i));
            chk($sformatf("pri%0d.crst", i), 64'(core_rst), 64'd0);
            tick();
        end
        @(negedge CLK);
        chk("pri.done", 64'(done), 64'd1);
        chk("pri.pass", 64'(pass), 64'd1);
        chk("pri.cc", 64'(cycle_count), 64'(LIMIT - 1));
        tick();

        // start and reload together in HALT: reload wins.
        drive(0, 0, 0, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("sr.rdy", 64'(load_ready), 64'd1);
        chk("sr.wl", 64'(words_loaded), 64'd0);
        chk("sr.crst", 64'(core_rst), 64'd1);
        chk("sr.done", 64'(done), 64'd0);
        tick();

        // Asynchronous reset mid-run, then from HALT.
        load_one();
        go_run();
        tick();
        tick();
        pulse_rst("arst.run");
        load_one();
        go_run();
        drive(0, 0, 0, 0, 0, 8);
        tick();
        tick();
        tick();
        @(negedge CLK);
        chk("arst.pre_done", 64'(done), 64'd1);
        tick();
        pulse_rst("arst.halt");

        // Random episodes.
        in_load = 1'b1;
        for (int ep = 0; ep < 150; ep++) begin
            if (in_load) rand_load(ep);
            rand_run(ep);
            choice = int'($urandom_range(0, 3));
            in_load = (choice != 0);
            if (choice == 1 || choice == 2) begin
                drive(0, 0, 0, (choice == 1) ? 1 : 0, 1, 0);
                tick();
                drive(0, 0, 0, 0, 0, 0);
                @(negedge CLK);
                chk(nm(ep, "rl.rdy"), 64'(load_ready), 64'd1);
                chk(nm(ep, "rl.wl"), 64'(words_loaded), 64'd0);
                chk(nm(ep, "rl.done"), 64'(done), 64'd0);
                tick();
            end else if (choice == 3) begin
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
